norz_mcycle_sequencer: RTL

//  T-state / machine-cycle sequencer for the NORZ bus. Takes cycle requests (opcode fetch, mem read, mem write) from
//  the instruction decoder and steps the T-state counter XPT. Drives XPT/notXPT into the phase decoders and generates the
//  bus strobes, WAIT insertion, refresh and BUSRQ/BUSAK arbitration. One cycle runs at a time; back-to-back cycles need no idle.

---
 rtl/norz_mcycle_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/norz_mcycle_sequencer.sv
// NORZ bus machine-cycle sequencer: steps T-states for fetch/read/write cycles,
// inserts wait states, and arbitrates bus release on BUSRQ at cycle boundaries.
module norz_mcycle_sequencer #(
    parameter int MAX_WAIT = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CYC_REQ,
    input  logic [1:0] CYC_TYPE,
    output logic       CYC_ACK,
    output logic       CYC_DONE,
    output logic       ILLEGAL,
    input  logic       TWAIT,
    output logic       WAIT_TIMEOUT,
    input  logic       BUSRQ,
    output logic       BUSAK,
    output logic [1:0] XPT,
    output logic [1:0] notXPT,
    output logic       M1,
    output logic       MREQ,
    output logic       RD,
    output logic       WR,
    output logic       RFSH,
    output logic       ADDR_OE,
    output logic       DATA_OE,
    output logic       SEL_AD_PC,
    output logic       INC_PC,
    output logic       DATA_LATCH,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_TW   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_BAK  = 3'd6
    } state_t;

    localparam logic [1:0] TY_FETCH   = 2'b00;
    localparam logic [1:0] TY_READ    = 2'b01;
    localparam logic [1:0] TY_WRITE   = 2'b10;
    localparam logic [1:0] TY_ILLEGAL = 2'b11;
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t     state_reg, state_next;
    logic [1:0] type_reg, type_next;
    logic [7:0] wcnt_reg, wcnt_next;
    logic       illegal_reg, illegal_next;
    logic       timeout_reg, timeout_next;
    logic       accept_point;
    logic       is_fetch, is_read, is_write;

    assign is_fetch = (type_reg == TY_FETCH);
    assign is_read  = (type_reg == TY_READ);
    assign is_write = (type_reg == TY_WRITE);

    // A new cycle may start from idle or from the final T-state of the current one.
    assign accept_point = (state_reg == S_IDLE) || (state_reg == S_T4) ||
                          ((state_reg == S_T3) && !is_fetch);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= S_IDLE;
            type_reg    <= TY_FETCH;
            wcnt_reg    <= 8'd0;
            illegal_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            type_reg    <= type_next;
            wcnt_reg    <= wcnt_next;
            illegal_reg <= illegal_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        type_next    = type_reg;
        wcnt_next    = wcnt_reg;
        illegal_next = 1'b0;
        timeout_next = 1'b0;
        if (accept_point) begin
            if (BUSRQ) begin
                state_next = S_BAK;
            end else if (CYC_REQ && (CYC_TYPE != TY_ILLEGAL)) begin
                state_next = S_T1;
                type_next  = CYC_TYPE;
                wcnt_next  = 8'd0;
            end else begin
                state_next   = S_IDLE;
                illegal_next = CYC_REQ;
            end
        end else begin
            case (state_reg)
                S_T1: state_next = S_T2;
                S_T2, S_TW: begin
                    if (!TWAIT) begin
                        state_next = S_T3;
                    end else if (wcnt_reg < WAIT_LIMIT) begin
                        state_next = S_TW;
                        wcnt_next  = wcnt_reg + 8'd1;
                    end else begin
                        state_next   = S_T3;
                        timeout_next = 1'b1;
                    end
                end
                S_T3:    state_next = S_T4;
                S_BAK:   state_next = BUSRQ ? S_BAK : S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        CYC_ACK    = 1'b0;
        CYC_DONE   = 1'b0;
        BUSAK      = 1'b0;
        XPT        = 2'd0;
        M1         = 1'b0;
        MREQ       = 1'b0;
        RD         = 1'b0;
        WR         = 1'b0;
        RFSH       = 1'b0;
        ADDR_OE    = 1'b0;
        DATA_OE    = 1'b0;
        SEL_AD_PC  = 1'b0;
        INC_PC     = 1'b0;
        DATA_LATCH = 1'b0;
        BUSY       = 1'b0;
        case (state_reg)
            S_T1: begin
                CYC_ACK   = 1'b1;
                BUSY      = 1'b1;
                ADDR_OE   = 1'b1;
                MREQ      = 1'b1;
                M1        = is_fetch;
                RD        = is_fetch || is_read;
                DATA_OE   = is_write;
                SEL_AD_PC = is_fetch;
            end
            S_T2, S_TW: begin
                XPT       = 2'd1;
                BUSY      = 1'b1;
                ADDR_OE   = 1'b1;
                MREQ      = 1'b1;
                M1        = is_fetch;
                RD        = is_fetch || is_read;
                WR        = is_write;
                DATA_OE   = is_write;
                SEL_AD_PC = is_fetch;
            end
            S_T3: begin
                XPT        = 2'd2;
                BUSY       = 1'b1;
                ADDR_OE    = 1'b1;
                MREQ       = 1'b1;
                RD         = is_read;
                WR         = is_write;
                DATA_OE    = is_write;
                RFSH       = is_fetch;
                DATA_LATCH = is_fetch || is_read;
                INC_PC     = is_fetch;
                SEL_AD_PC  = is_fetch;
                CYC_DONE   = !is_fetch;
            end
            S_T4: begin
                XPT       = 2'd3;
                BUSY      = 1'b1;
                ADDR_OE   = 1'b1;
                MREQ      = 1'b1;
                RFSH      = 1'b1;
                SEL_AD_PC = 1'b1;
                CYC_DONE  = 1'b1;
            end
            S_BAK:   BUSAK = 1'b1;
            default: ;
        endcase
    end

    assign ILLEGAL      = illegal_reg;
    assign WAIT_TIMEOUT = timeout_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_notxpt
            assign notXPT[gi] = ~XPT[gi];
        end
    endgenerate

endmodule
